// File: rtl/spi_slave_rx_frame.sv
// SPI slave frame receiver: SPI inputs are synchronised and glitch-filtered into
// i_clock, NUM_WORDS words are assembled and the frame is published with one strobe.
module spi_slave_rx_frame #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_WORDS     = 2,
    parameter int FILTER_CYCLES = 2,
    parameter bit CPOL          = 1'b0,
    parameter bit CPHA          = 1'b0,
    parameter bit MSB_FIRST     = 1'b1
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_spi_cs_n,
    input  logic                            i_spi_sclk,
    input  logic                            i_spi_mosi,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] o_data,
    output logic                            o_data_valid,
    output logic                            o_frame_error,
    output logic                            o_busy
);

    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int FILT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_CS, IDLE, RECEIVE, DONE} state_t;

    logic [1:0] csSync_q, sclkSync_q, mosiSync_q;
    logic csFilt_q, csPrev_q, sclkFilt_q, sclkPrev_q;
    logic [FILT_W-1:0] csCnt_q, sclkCnt_q;
    logic csFall, csRise, sampleEdge;

    state_t state_q;
    logic [DATA_WIDTH-1:0] shiftReg_q, shift_d;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] frameBuf_q, frame_d;
    logic [BIT_W-1:0] bitCnt_q;
    logic [WORD_W-1:0] wordCnt_q;
    logic extra_q;
    logic [NUM_WORDS*DATA_WIDTH-1:0] data_q;
    logic dataValid_q, frameError_q, busy_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            csSync_q   <= 2'b00;
            sclkSync_q <= {2{CPOL}};
            mosiSync_q <= 2'b00;
        end else begin
            csSync_q   <= {csSync_q[0], i_spi_cs_n};
            sclkSync_q <= {sclkSync_q[0], i_spi_sclk};
            mosiSync_q <= {mosiSync_q[0], i_spi_mosi};
        end
    end

    // A level is accepted only after FILTER_CYCLES consecutive disagreeing samples;
    // the previous-level copies turn level changes into single-cycle edge pulses.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            csFilt_q   <= 1'b0;
            csPrev_q   <= 1'b0;
            csCnt_q    <= '0;
            sclkFilt_q <= CPOL;
            sclkPrev_q <= CPOL;
            sclkCnt_q  <= '0;
        end else begin
            csPrev_q   <= csFilt_q;
            sclkPrev_q <= sclkFilt_q;
            if (csSync_q[1] == csFilt_q) begin
                csCnt_q <= '0;
            end else if (csCnt_q == FILT_LAST) begin
                csFilt_q <= csSync_q[1];
                csCnt_q  <= '0;
            end else begin
                csCnt_q <= csCnt_q + 1'b1;
            end
            if (sclkSync_q[1] == sclkFilt_q) begin
                sclkCnt_q <= '0;
            end else if (sclkCnt_q == FILT_LAST) begin
                sclkFilt_q <= sclkSync_q[1];
                sclkCnt_q  <= '0;
            end else begin
                sclkCnt_q <= sclkCnt_q + 1'b1;
            end
        end
    end

    assign csFall     = csPrev_q & ~csFilt_q;
    assign csRise     = ~csPrev_q & csFilt_q;
    assign sampleEdge = CPHA ? ((sclkPrev_q != CPOL) && (sclkFilt_q == CPOL))
                             : ((sclkPrev_q == CPOL) && (sclkFilt_q != CPOL));

    always_comb begin
        shift_d = MSB_FIRST ? {shiftReg_q[DATA_WIDTH-2:0], mosiSync_q[1]}
                            : {mosiSync_q[1], shiftReg_q[DATA_WIDTH-1:1]};
        frame_d = frameBuf_q;
        frame_d[wordCnt_q] = shift_d;
    end

    // Frame FSM; a CS rise is checked before the sample edge so it wins a tie.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= WAIT_CS;
            shiftReg_q   <= '0;
            frameBuf_q   <= '0;
            bitCnt_q     <= '0;
            wordCnt_q    <= '0;
            extra_q      <= 1'b0;
            data_q       <= '0;
            dataValid_q  <= 1'b0;
            frameError_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            dataValid_q  <= 1'b0;
            frameError_q <= 1'b0;
            case (state_q)
                WAIT_CS: begin
                    if (csFilt_q) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (csFall) begin
                        bitCnt_q  <= '0;
                        wordCnt_q <= '0;
                        extra_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (csRise) begin
                        frameError_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end else if (sampleEdge) begin
                        shiftReg_q <= shift_d;
                        if (bitCnt_q == BIT_LAST) begin
                            bitCnt_q   <= '0;
                            frameBuf_q <= frame_d;
                            if (wordCnt_q == WORD_LAST) begin
                                data_q      <= frame_d;
                                dataValid_q <= 1'b1;
                                busy_q      <= 1'b0;
                                state_q     <= DONE;
                            end else begin
                                wordCnt_q <= wordCnt_q + 1'b1;
                            end
                        end else begin
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (csRise) begin
                        frameError_q <= extra_q;
                        state_q      <= IDLE;
                    end else if (sampleEdge) begin
                        extra_q <= 1'b1;
                    end
                end
                default: state_q <= WAIT_CS;
            endcase
        end
    end

    assign o_data        = data_q;
    assign o_data_valid  = dataValid_q;
    assign o_frame_error = frameError_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_rx_frame.sv
// Bench for spi_slave_rx_frame: four instances (SPI modes 0..3, alternating bit order)
// share one bit stream; an event-queue model predicts every frame outcome.
module tb_spi_slave_rx_frame;

    typedef struct packed {
        logic        isErr;
        logic [31:0] data;
    } ev_t;

    logic clock, reset, csN, sclkBase, mosi;
    logic [3:0][31:0] dData;
    logic [3:0] dValid, dErr, dBusy;

    ev_t evQ[$];
    int rdPtr[4] = '{default: 0};
    logic [31:0] expData[4] = '{default: 32'h0};
    int nChecks = 0;
    int nPass = 0;

    for (genvar g = 0; g < 4; g++) begin : gDut
        localparam bit P_CPOL = (g / 2) == 1;
        localparam bit P_CPHA = (g % 2) == 1;
        localparam bit P_MSB  = (g % 2) == 0;
        spi_slave_rx_frame #(
            .DATA_WIDTH(16), .NUM_WORDS(2), .FILTER_CYCLES(2),
            .CPOL(P_CPOL), .CPHA(P_CPHA), .MSB_FIRST(P_MSB)
        ) uDut (
            .i_clock(clock),
            .i_reset(reset),
            .i_spi_cs_n(csN),
            .i_spi_sclk(sclkBase ^ P_CPOL),
            .i_spi_mosi(mosi),
            .o_data(dData[g]),
            .o_data_valid(dValid[g]),
            .o_frame_error(dErr[g]),
            .o_busy(dBusy[g])
        );
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        nChecks++;
        if (actual === required) nPass++;
        else $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Odd instances receive LSB first, so each word arrives bit-reversed.
    function automatic logic [31:0] xform(input int g, input logic [31:0] f);
        logic [31:0] r;
        if (g % 2 == 0) return f;
        for (int b = 0; b < 16; b++) begin
            r[b]      = f[15 - b];
            r[16 + b] = f[31 - b];
        end
        return r;
    endfunction

    // Every cycle: pulses must match the next queued event, o_data must match the model.
    initial begin
        bit ok;
        forever begin
            @(posedge clock);
            #2;
            for (int g = 0; g < 4; g++) begin
                if (reset) begin
                    expData[g] = 32'h0;
                    rdPtr[g]   = evQ.size();
                    checkOutput("resetData", dData[g], 32'h0);
                    checkOutput("resetPulses", {30'b0, dValid[g], dErr[g]}, 32'h0);
                    checkOutput("resetBusy", {31'b0, dBusy[g]}, 32'h0);
                end else begin
                    if (dValid[g]) begin
                        ok = 1'b0;
                        if (rdPtr[g] < evQ.size()) ok = !evQ[rdPtr[g]].isErr;
                        checkOutput("validExpected", {31'b0, ok}, 32'h1);
                        if (ok) begin
                            expData[g] = xform(g, evQ[rdPtr[g]].data);
                            rdPtr[g]++;
                        end
                    end
                    if (dErr[g]) begin
                        ok = 1'b0;
                        if (rdPtr[g] < evQ.size()) ok = evQ[rdPtr[g]].isErr;
                        checkOutput("errorExpected", {31'b0, ok}, 32'h1);
                        if (ok) rdPtr[g]++;
                    end
                    checkOutput("frameData", dData[g], expData[g]);
                end
            end
        end
    end

    // Sends nBits bits of frame (word 0 first, each word MSB first on the wire);
    // bits past 32 are random. Optional mid-frame reset and 1-cycle glitches.
    task automatic applyStimulus(input int nBits, input logic [31:0] frame, input int resetBit, input bit glitch);
        int lowLen, highLen;
        bit wasReset;
        wasReset = 1'b0;
        csN = 1'b0;
        waitCycles(10);
        for (int i = 0; i < nBits; i++) begin
            lowLen  = 12 + int'($urandom_range(0, 4));
            highLen = 8 + int'($urandom_range(0, 3));
            waitCycles(6);
            mosi = (i < 32) ? frame[(i / 16) * 16 + 15 - (i % 16)] : 1'($urandom_range(0, 1));
            if (i == 31 && !wasReset) evQ.push_back(ev_t'{1'b0, frame});
            if (i == 5 && !wasReset)
                for (int g = 0; g < 4; g++) checkOutput("busyInFrame", {31'b0, dBusy[g]}, 32'h1);
            if (i == resetBit) begin
                reset = 1'b1;
                waitCycles(2);
                reset = 1'b0;
                wasReset = 1'b1;
                waitCycles(lowLen - 8);
            end else if (glitch && i == 11) begin
                csN = 1'b1;
                waitCycles(1);
                csN = 1'b0;
                waitCycles(lowLen - 7);
            end else begin
                waitCycles(lowLen - 6);
            end
            sclkBase = 1'b1;
            if (glitch && i == 7) begin
                waitCycles(4);
                sclkBase = 1'b0;
                waitCycles(1);
                sclkBase = 1'b1;
                waitCycles(highLen - 5);
            end else begin
                waitCycles(highLen);
            end
            sclkBase = 1'b0;
        end
        waitCycles(8);
        if (!wasReset && nBits != 32) evQ.push_back(ev_t'{1'b1, 32'h0});
        csN = 1'b1;
        waitCycles(14);
        for (int g = 0; g < 4; g++) begin
            checkOutput("eventsDrained", rdPtr[g], evQ.size());
            checkOutput("busyIdle", {31'b0, dBusy[g]}, 32'h0);
        end
    endtask

    initial begin
        int nb, kind;
        reset = 1'b1;
        csN = 1'b1;
        sclkBase = 1'b0;
        mosi = 1'b0;
        waitCycles(5);
        reset = 1'b0;
        waitCycles(20);

        applyStimulus(32, 32'h1234_A5C3, -1, 1'b0);
        checkOutput("litMode0", dData[0], 32'h1234_A5C3);
        checkOutput("litMode1Lsb", dData[1], 32'h2C48_C3A5);
        checkOutput("litMode2", dData[2], 32'h1234_A5C3);
        checkOutput("litMode3Lsb", dData[3], 32'h2C48_C3A5);

        applyStimulus(32, 32'h0000_0001, -1, 1'b0);
        checkOutput("litOneMsb", {16'h0, dData[0][15:0]}, 32'h0001);
        checkOutput("litOneLsb", {16'h0, dData[1][15:0]}, 32'h8000);

        applyStimulus(20, $urandom, -1, 1'b0);
        checkOutput("litShortHold", dData[0], 32'h0000_0001);
        checkOutput("litShortHoldLsb", dData[1], 32'h0000_8000);

        applyStimulus(32, $urandom, -1, 1'b0);
        applyStimulus(33, 32'hDEAD_BEEF, -1, 1'b0);
        checkOutput("litLong", dData[0], 32'hDEAD_BEEF);
        checkOutput("litLongLsb", dData[1], 32'hB57B_F77D);

        applyStimulus(32, 32'hCAFE_0F0F, -1, 1'b1);
        checkOutput("litGlitch", dData[0], 32'hCAFE_0F0F);

        applyStimulus(32, $urandom, 10, 1'b0);
        checkOutput("litAfterReset", dData[0], 32'h0);
        applyStimulus(32, 32'h1357_9BDF, -1, 1'b0);
        checkOutput("litRecover", dData[0], 32'h1357_9BDF);

        for (int f = 0; f < 20; f++) begin
            kind = int'($urandom_range(0, 3));
            nb = (kind == 0) ? int'($urandom_range(1, 31)) :
                 (kind == 3) ? int'($urandom_range(33, 35)) : 32;
            applyStimulus(nb, $urandom, -1, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx_frame.md
# spi_slave_rx_frame

Parametrised SPI slave receiver that captures a fixed-length frame of NUM_WORDS words of DATA_WIDTH bits from an external SPI master (ADC/MCU control link) and presents the whole frame as one parallel bus with a single-cycle valid strobe. All SPI inputs are synchronised and glitch-filtered into the i_clock domain, so the block has no SPI-clocked logic. It supports all four SPI modes and selectable bit order, and it flags frames that are short or overlong.

## Interface
- DATA_WIDTH, 16, bits per word (≥2)
- NUM_WORDS, 2, words per frame (≥1)
- FILTER_CYCLES, 2, consecutive identical synchronised samples required before SCLK/CS level is accepted (≥1)
- CPOL, 0, SCLK idle level
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- MSB_FIRST, 1, 1 = first bit of each word lands in MSB
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_spi_cs_n  in  1  chip select, active low, asynchronous to i_clock
- i_spi_sclk  in  1  SPI clock, asynchronous
- i_spi_mosi  in  1  SPI data, asynchronous
- o_data  out  NUM_WORDS*DATA_WIDTH  last complete frame; word 0 (first received) at [DATA_WIDTH-1:0]
- o_data_valid  out  1  one-cycle pulse when o_data updates
- o_frame_error  out  1  one-cycle pulse on a bad frame
- o_busy  out  1  high while in RECEIVE

## Operation
- Input path: each SPI input goes through a 2-flop synchroniser. SCLK and CS then pass through a filter; the filtered level changes only on the cycle where the FILTER_CYCLES-th consecutive sample differing from the current filtered level is seen. MOSI is sampled from its synchroniser output on the detected edge cycle.
- Edge detect: leading edge = filtered SCLK leaving CPOL; trailing edge = returning to CPOL. The sample edge is leading if CPHA=0, trailing if CPHA=1.
- Shift register DATA_WIDTH bits. With MSB_FIRST, shift left and insert at LSB; otherwise shift right and insert at MSB.
- bit_cnt counts 0..DATA_WIDTH-1; word_cnt counts 0..NUM_WORDS-1; each is $clog2-sized with a minimum of 1 bit.
- The frame buffer holds NUM_WORDS words. A completed word is written to slot word_cnt. o_data is a separate register loaded from the buffer (plus the final word) only on frame completion, so o_data is never partially updated.
- FSM:
  - WAIT_CS (reset state): ignores SCLK. Goes to IDLE when filtered CS is inactive. If CS was low during reset, the in-progress frame is not captured.
  - IDLE: on a filtered CS falling edge, clear bit_cnt, word_cnt and the extra flag, then go to RECEIVE.
  - RECEIVE: each sample edge shifts in one bit. After the last bit of the last word, load o_data, pulse o_data_valid, and go to DONE. A CS rise in RECEIVE pulses o_frame_error, leaves o_data unchanged, and goes to IDLE.
  - DONE: any further sample edge sets the extra flag. On CS rise, pulse o_frame_error if extra is set, then go to IDLE.
- Simultaneous sample edge and CS rise in the same cycle: the CS rise wins and the bit is discarded.
- Sample edges outside RECEIVE/DONE are ignored.

## Timing
- Reset values:
  - o_data = 0, o_data_valid = 0, o_frame_error = 0, o_busy = 0.
  - Filtered CS = 0 (active), filtered SCLK = CPOL.
  - Counters and shift register = 0, state = WAIT_CS.
- Input latency: a raw SCLK/CS transition becomes a detected edge 2+FILTER_CYCLES cycles later, for a clean input.
- o_data_valid is asserted on the cycle after the detected final sample edge. o_data is valid from that same cycle and holds until the next completed frame.
- o_frame_error is asserted on the cycle after the detected CS rise.
- o_busy goes high the cycle after the detected CS fall and low the cycle after completion or abort.
- Constraint: SCLK high and low phases must each be ≥ FILTER_CYCLES+2 i_clock periods. CS inactive time must be ≥ FILTER_CYCLES+2 periods.
- Glitches shorter than FILTER_CYCLES cycles on SCLK or CS produce no edge.

## Test plan
- Mode 0, defaults: send 0xA5C3 then 0x1234 → one o_data_valid pulse, o_data = 0x1234_A5C3, no o_frame_error.
- Each of modes 1/2/3 and MSB_FIRST=0: send 0x0001 as word 0 → o_data[15:0] = 0x0001 for MSB_FIRST=1 and 0x8000 for MSB_FIRST=0. No other bits change.
- CS released after 20 bits → o_frame_error pulse, no o_data_valid, o_data still holds the previous frame. The next full frame is received correctly.
- 33 clocks in one CS window → o_data_valid after bit 32 carries the first 32 bits, then o_frame_error at CS rise.
- Inject 1-cycle SCLK and CS glitches (FILTER_CYCLES=2) mid-word → data unaffected and no error.
- Assert i_reset mid-frame with CS held low → outputs clear immediately. The remaining bits are ignored (no valid, no error). The frame after the CS rise is received correctly.
